// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared types and constants for the FIFO drain packer
package fifo_drain_pkg;

    localparam int DEF_DATA_WIDTH = 7;
    localparam int DEF_PKT_LEN    = 4;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // A one-word packet still needs a 1-bit beat register.
    function automatic int beat_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

    localparam int BEAT_W = beat_width(DEF_PKT_LEN);

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry in-order holding buffer with registered head
import fifo_drain_pkg::*;

module skid_buf2 #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head
);

    occ_t                  state_q;
    occ_t                  state_d;
    logic [DATA_WIDTH-1:0] ent0_q;
    logic [DATA_WIDTH-1:0] ent1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: if (push) state_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop) begin
                    state_d = OCC_TWO;
                end else if (pop && !push) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: if (pop && !push) state_d = OCC_ONE;
            default: state_d = OCC_EMPTY;
        endcase
    end

    // ent0 is always the head; it only changes when empty or on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            case (state_q)
                OCC_EMPTY: if (push) ent0_q <= push_data;
                OCC_ONE: begin
                    if (push && pop) begin
                        ent0_q <= push_data;
                    end else if (push) begin
                        ent1_q <= push_data;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        ent0_q <= ent1_q;
                        if (push) ent1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ  = state_q;
    assign head = ent0_q;

endmodule

// File: rtl/fifo_drain_packer.sv
// rtl/fifo_drain_packer.sv - drains the read side of the async FIFO into a packetised stream
import fifo_drain_pkg::*;

module fifo_drain_packer #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_LEN    = DEF_PKT_LEN,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_W-1:0]      pkt_count
);

    localparam int                 BW        = beat_width(PKT_LEN);
    localparam logic [BW-1:0]      LAST_BEAT = BW'(PKT_LEN - 1);

    occ_t          occ;
    logic          inflight_q;
    logic [BW-1:0] beat_q;
    logic          pop;
    logic [1:0]    slots_used;

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head      (m_data)
    );

    assign m_valid = (occ != OCC_EMPTY);
    assign m_last  = m_valid && (beat_q == LAST_BEAT);
    assign pop     = m_valid && m_ready;

    // Reserve a slot for every word already requested; a pop this cycle frees one.
    assign slots_used = occ + {1'b0, inflight_q} - {1'b0, pop};
    assign fifo_rd_en = rst_n && !fifo_empty && (slots_used < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
            pkt_count  <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (pop) begin
                if (m_last) begin
                    beat_q    <= '0;
                    pkt_count <= pkt_count + CNT_W'(1);
                end else begin
                    beat_q <= beat_q + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// tb/tb_fifo_drain_packer.sv - scoreboard bench for fifo_drain_packer
module tb_fifo_drain_packer;

    localparam int DW    = 7;
    localparam int PLEN0 = 4;
    localparam int PLEN1 = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fifo_empty   [2];
    logic          fifo_rd_en   [2];
    logic [DW-1:0] fifo_rd_data [2];
    logic          m_valid      [2];
    logic          m_ready      [2];
    logic [DW-1:0] m_data       [2];
    logic          m_last       [2];
    logic [15:0]   pkt_count0;
    logic [3:0]    pkt_count1;

    always #5 clk = ~clk;

    fifo_drain_packer #(.DATA_WIDTH(DW), .PKT_LEN(PLEN0), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty[0]),
        .fifo_rd_en   (fifo_rd_en[0]),
        .fifo_rd_data (fifo_rd_data[0]),
        .m_valid      (m_valid[0]),
        .m_ready      (m_ready[0]),
        .m_data       (m_data[0]),
        .m_last       (m_last[0]),
        .pkt_count    (pkt_count0)
    );

    fifo_drain_packer #(.DATA_WIDTH(DW), .PKT_LEN(PLEN1), .CNT_W(4)) u_dut_p1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty[1]),
        .fifo_rd_en   (fifo_rd_en[1]),
        .fifo_rd_data (fifo_rd_data[1]),
        .m_valid      (m_valid[1]),
        .m_ready      (m_ready[1]),
        .m_data       (m_data[1]),
        .m_last       (m_last[1]),
        .pkt_count    (pkt_count1)
    );

    logic [DW-1:0] src0 [$];
    logic [DW-1:0] src1 [$];
    logic [DW:0]   exp0 [$];
    logic [DW:0]   exp1 [$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          beat_m [2];
    int          pops [2];
    int          rd_pulses [2];
    int          first_valid_cyc;
    bit          gap_en;
    bit          rand_rdy;
    bit          rdy_val [2];
    logic        prev_v [2];
    logic        prev_r [2];
    logic [DW:0] prev_w [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        fifo_empty[0] = (src0.size() == 0) || (gap_en && (cyc % 2 == 1));
        fifo_empty[1] = (src1.size() == 0);
        m_ready[0]    = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val[0];
        m_ready[1]    = rdy_val[1];
    endtask

    task automatic load(input int l, input int first, input int n);
        logic [DW-1:0] w;
        logic          lst;
        int            plen;
        plen = (l == 0) ? PLEN0 : PLEN1;
        for (int i = 0; i < n; i++) begin
            w         = DW'(first + i);
            lst       = (beat_m[l] == plen - 1);
            beat_m[l] = lst ? 0 : beat_m[l] + 1;
            if (l == 0) begin
                src0.push_back(w);
                exp0.push_back({lst, w});
            end else begin
                src1.push_back(w);
                exp1.push_back({lst, w});
            end
        end
        drive_inputs();
    endtask

    task automatic sample_lane(input int l);
        logic [DW:0] e;
        int          qsize;
        check("rd_while_empty", 32'(fifo_rd_en[l] && fifo_empty[l]), 32'd0);
        if (fifo_rd_en[l]) rd_pulses[l]++;
        if (prev_v[l] && !prev_r[l]) begin
            check("hold_valid", 32'(m_valid[l]), 32'd1);
            check("hold_word", 32'({m_last[l], m_data[l]}), 32'(prev_w[l]));
        end
        if (l == 0 && m_valid[0] && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid[l] && m_ready[l]) begin
            pops[l]++;
            qsize = (l == 0) ? exp0.size() : exp1.size();
            check("beat_expected", 32'(qsize > 0), 32'd1);
            if (qsize > 0) begin
                if (l == 0) e = exp0.pop_front();
                else        e = exp1.pop_front();
                check("beat_data", 32'(m_data[l]), 32'(e[DW-1:0]));
                check("beat_last", 32'(m_last[l]), 32'(e[DW]));
            end
        end
        prev_v[l] = m_valid[l];
        prev_r[l] = m_ready[l];
        prev_w[l] = {m_last[l], m_data[l]};
    endtask

    task automatic step();
        logic rd_now0;
        logic rd_now1;
        @(negedge clk);
        sample_lane(0);
        sample_lane(1);
        rd_now0 = fifo_rd_en[0];
        rd_now1 = fifo_rd_en[1];
        @(posedge clk);
        #1;
        cyc++;
        if (rd_now0 && src0.size() > 0) fifo_rd_data[0] = src0.pop_front();
        if (rd_now1 && src1.size() > 0) fifo_rd_data[1] = src1.pop_front();
        drive_inputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp0.size() + exp1.size()) != 0; i++) step();
        repeat (2) step();
        check("drain_done", 32'(exp0.size() + exp1.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(m_valid[0]), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en[0]), 32'd0);
        check("rst_pkt_count", 32'(pkt_count0), 32'd0);
        check("rst_data_last", 32'({m_last[0], m_data[0]}), 32'd0);
        check("rst_pkt_count_p1", 32'(pkt_count1), 32'd0);
        src0.delete();
        src1.delete();
        exp0.delete();
        exp1.delete();
        for (int l = 0; l < 2; l++) begin
            beat_m[l] = 0;
            prev_v[l] = 1'b0;
            prev_r[l] = 1'b0;
        end
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        for (int l = 0; l < 2; l++) begin
            fifo_empty[l]   = 1'b0;
            fifo_rd_data[l] = '0;
            m_ready[l]      = 1'b1;
            rdy_val[l]      = 1'b1;
            beat_m[l]       = 0;
            pops[l]         = 0;
            rd_pulses[l]    = 0;
            prev_v[l]       = 1'b0;
            prev_r[l]       = 1'b0;
            prev_w[l]       = '0;
        end
        gap_en          = 1'b0;
        rand_rdy        = 1'b0;
        first_valid_cyc = -1;
        #2;
        do_reset();

        // streaming: 8 words, two packets
        c0              = cyc;
        first_valid_cyc = -1;
        pops[0]         = 0;
        load(0, 1, 8);
        repeat (10) step();
        check("stream_latency", 32'(first_valid_cyc - c0), 32'd2);
        check("stream_pops", 32'(pops[0]), 32'd8);
        check("stream_pkt_count", 32'(pkt_count0), 32'd2);

        // backpressure with a full source
        rdy_val[0]   = 1'b0;
        rd_pulses[0] = 0;
        load(0, 1, 16);
        repeat (6) step();
        check("bp_rd_pulses", 32'(rd_pulses[0]), 32'd2);
        check("bp_head_valid", 32'(m_valid[0]), 32'd1);
        check("bp_head_data", 32'(m_data[0]), 32'h01);
        rdy_val[0] = 1'b1;
        drive_inputs();
        drain();
        check("bp_pkt_count", 32'(pkt_count0), 32'd6);

        // gapped source and random downstream stalls
        gap_en   = 1'b1;
        rand_rdy = 1'b1;
        load(0, 'h11, 8);
        drain();
        gap_en   = 1'b0;
        rand_rdy = 1'b0;
        drive_inputs();
        check("gap_pkt_count", 32'(pkt_count0), 32'd8);

        // reset two beats into a packet, then a fresh packet
        pops[0] = 0;
        load(0, 'h19, 6);
        for (int i = 0; i < 50 && pops[0] < 2; i++) step();
        do_reset();
        load(0, 'h21, 4);
        drain();
        check("post_rst_pkt_count", 32'(pkt_count0), 32'd1);

        // one-word packets with a 4-bit counter wrapping
        load(1, 5, 17);
        drain();
        check("wrap_pkt_count", 32'(pkt_count1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_drain_packer.md
# fifo_drain_packer

Read-side consumer of the 16-deep dual-clock FIFO, running entirely in the FIFO's read clock domain. It issues read strobes whenever the FIFO reports non-empty, absorbs the FIFO's one-cycle read latency in a two-entry holding buffer, and presents words on a valid/ready stream. It groups every PKT_LEN consecutive words into a packet marked with `m_last`, and counts completed packets for downstream framing and debug.

## Interface
- `DATA_WIDTH`, default 7: word width; must equal the FIFO's data width.
- `PKT_LEN`, default 4: words per packet; legal range 1..256.
- `CNT_W`, default 16: width of the packet counter.

Ports:
- `clk`  in  1  read-domain clock; the same clock as the FIFO's `rd_clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag, already synchronous to `clk`.
- `fifo_rd_en`  out  1  read strobe to the FIFO's `rd_en`.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO's `rd_data`; valid the cycle after `fifo_rd_en`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  the current word is the final word of a packet.
- `pkt_count`  out  CNT_W  completed packets, modulo 2^CNT_W.

## Operation
- Clock and reset: single clock `clk`; reset is asynchronous and active-low (`rst_n`).
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `pkt_count`=0. Internal state also clears: `occ`=0, `inflight`=0, beat index=0.
- Holding buffer:
  - 2 entries, FIFO order.
  - `occ` (0..2) tracks stored words.
  - `inflight` (0/1) means `fifo_rd_en` was asserted in the previous cycle.
- Pop: `pop = m_valid && m_ready`.
- Read rule: `fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2`.
  - This path is combinational from `m_ready` and `fifo_empty`.
  - The buffer never overflows; every in-flight word has a guaranteed slot.
- Capture: when `inflight`=1, `fifo_rd_data` is written into the buffer at the clock edge. A simultaneous pop and capture in the same edge is legal; `occ` is then unchanged.
- Output: `m_valid = (occ != 0)`. `m_data` is the head entry, driven from a register.
- Packetization: beat index increments on each pop. On a pop with `m_last`=1 it wraps to 0.
- `m_last = m_valid && (beat == PKT_LEN-1)`. With PKT_LEN=1, every word is last.
- `pkt_count` increments on each pop with `m_last`=1 and wraps at 2^CNT_W.
- Stream rules:
  - Once `m_valid` rises, `m_valid`, `m_data` and `m_last` stay stable until the word is popped.
  - `m_valid` never depends combinationally on `m_ready`.
- Mid-operation reset:
  - Buffered words and any in-flight word are discarded. The FIFO's read pointer has already advanced, so those words are lost by design.
  - The partial packet is abandoned; after reset the beat index restarts at 0.
- `fifo_empty` high while `inflight`=1: the in-flight word is still captured. Only new reads are blocked.

## Timing
- `fifo_rd_en` is high in cycle k. The data is captured at the end of cycle k+1, and `m_valid` is high in cycle k+2.
- Latency from `fifo_empty` falling to `m_valid` rising: 2 cycles, with the buffer empty and `m_ready`=1.
- Steady-state throughput: 1 word per cycle while `m_ready`=1 and the FIFO stays non-empty.
- Backpressure: with `m_ready`=0, at most 2 reads are issued after the last pop, then `fifo_rd_en` stays 0.
- `pkt_count` updates at the edge that completes the last pop. It is visible the following cycle.

## Structure
- Package `fifo_drain_pkg`:
  - occupancy enum `occ_t` {OCC_EMPTY, OCC_ONE, OCC_TWO}; this is the buffer state machine.
  - `BEAT_W = $clog2(PKT_LEN)` (minimum 1).
  - default parameter constants.
- Sub-module `skid_buf2`:
  - a two-entry register buffer with push/pop, `occ` output and head data.
  - The top level holds only the read-issue logic, the beat counter and `pkt_count`.
- States and transitions for `occ_t`:
  - EMPTY→ONE on push.
  - ONE→TWO on push without pop.
  - ONE→EMPTY on pop without push.
  - TWO→ONE on pop without push.
  - push with pop leaves the state unchanged.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → immediately `m_valid`=0, `fifo_rd_en`=0, `pkt_count`=0.
- Streaming: 8 words 0x01..0x08 with `m_ready`=1 and PKT_LEN=4 → one word per cycle after 2 cycles of latency; `m_last` on 0x04 and 0x08; `pkt_count`=2.
- Backpressure: FIFO full and `m_ready`=0 for 6 cycles → exactly 2 `fifo_rd_en` pulses; `m_data` held at 0x01; on release, 0x01..0x10 delivered in order with none lost.
- Gapped source: `fifo_empty` toggles every cycle → `fifo_rd_en` is never high while empty; no duplicate or spurious beats.
- Counter wrap: PKT_LEN=1, CNT_W=4, 17 words → `pkt_count`=1.
- Reset mid-packet: reset after 2 beats of a 4-word packet, then 4 new words → `m_last` only on the 4th new word.
